// File: rtl/cp0_exc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_pkg
//  Description : Shared CP0 definitions: register numbers, exception codes,
//                SR/Cause field positions and write masks, EXL state type.
//  Revision    : 1.0  initial release
// ============================================================================
package cp0_pkg;

   typedef logic [4:0] cp0_reg_t;
   typedef logic [4:0] cp0_exc_code_t;

   // CP0 register numbers
   localparam cp0_reg_t REG_SR    = 5'd12;
   localparam cp0_reg_t REG_CAUSE = 5'd13;
   localparam cp0_reg_t REG_EPC   = 5'd14;
   localparam cp0_reg_t REG_PRID  = 5'd15;

   // Exception codes (0 on the pipeline means "no exception")
   localparam cp0_exc_code_t EXC_NONE = 5'd0;
   localparam cp0_exc_code_t EXC_INT  = 5'd0;
   localparam cp0_exc_code_t EXC_ADEL = 5'd4;
   localparam cp0_exc_code_t EXC_ADES = 5'd5;
   localparam cp0_exc_code_t EXC_RI   = 5'd10;
   localparam cp0_exc_code_t EXC_OV   = 5'd12;

   // SR field positions
   localparam int SR_IE_BIT  = 0;
   localparam int SR_EXL_BIT = 1;
   localparam int SR_IM_LSB  = 10;
   localparam int SR_IM_MSB  = 15;
   localparam logic [31:0] SR_WMASK = 32'h0000_FC03;

   // Cause field positions
   localparam int CAUSE_BD_BIT  = 31;
   localparam int CAUSE_IP_LSB  = 10;
   localparam int CAUSE_IP_MSB  = 15;
   localparam int CAUSE_EXC_LSB = 2;
   localparam int CAUSE_EXC_MSB = 6;

   // Exception-level state, stored as SR.EXL
   typedef enum logic {
      ST_NORMAL  = 1'b0,
      ST_HANDLER = 1'b1
   } exl_state_e;

endpackage : cp0_pkg
`default_nettype wire

// File: rtl/cp0_exc_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_exc_ctrl_if
//  Description : M-stage <-> CP0 signal bundle. The pipeline is the master,
//                CP0 is the slave that returns read data and the trap request.
//  Revision    : 1.0  initial release
// ============================================================================
interface cp0_exc_ctrl_if;
   import cp0_pkg::*;

   logic [31:0]   pc_m;
   logic          bd_m;
   cp0_exc_code_t exc_code_m;
   logic [5:0]    hw_int;
   logic          cp0_we;
   cp0_reg_t      cp0_addr;
   logic [31:0]   cp0_wdata;
   logic          eret_m;
   logic [31:0]   cp0_rdata;
   logic [31:0]   epc_out;
   logic          int_exc_req;
   logic [31:0]   handler_pc;

   modport master (
      output pc_m, bd_m, exc_code_m, hw_int, cp0_we, cp0_addr, cp0_wdata, eret_m,
      input  cp0_rdata, epc_out, int_exc_req, handler_pc
   );

   modport slave (
      input  pc_m, bd_m, exc_code_m, hw_int, cp0_we, cp0_addr, cp0_wdata, eret_m,
      output cp0_rdata, epc_out, int_exc_req, handler_pc
   );

endinterface : cp0_exc_ctrl_if
`default_nettype wire

// File: rtl/cp0_exc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_exc_ctrl
//  Description : Coprocessor 0 at the M stage. Resolves interrupts and
//                exceptions into a single flush/redirect request, records
//                EPC/Cause, and serves mfc0/mtc0/eret.
//  Revision    : 1.0  initial release
// ============================================================================
module cp0_exc_ctrl
   import cp0_pkg::*;
#(
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [31:0] PRID_VAL   = 32'h2020_0290
) (
   input  wire logic       clk,
   input  wire logic       reset,
   cp0_exc_ctrl_if.slave   bus
);

   exl_state_e    state_q, state_d;
   logic [5:0]    im_q, im_d;
   logic          ie_q, ie_d;
   logic          bd_q, bd_d;
   logic [5:0]    ip_q;
   cp0_exc_code_t exccode_q, exccode_d;
   logic [31:0]   epc_q, epc_d;

   logic          int_pend;
   logic          exc_pend;
   logic          trap;
   logic          mtc0_ok;
   logic          sr_wr;
   logic          epc_wr;
   logic [31:0]   sr_word;
   logic [31:0]   cause_word;

   // Trap decision; a trapping instruction's mtc0 must not commit
   always_comb begin
      int_pend = (|(bus.hw_int & im_q)) & ie_q & (state_q == ST_NORMAL);
      exc_pend = (bus.exc_code_m != EXC_NONE) & (state_q == ST_NORMAL);
      trap     = int_pend | exc_pend;
      mtc0_ok  = bus.cp0_we & ~trap;
      sr_wr    = mtc0_ok & (bus.cp0_addr == REG_SR);
      epc_wr   = mtc0_ok & (bus.cp0_addr == REG_EPC);
   end

   // EXL state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_NORMAL;
      else       state_q <= state_d;
   end

   // EXL next state: trap beats eret, eret beats a software write of EXL
   always_comb begin
      state_d = state_q;
      if (trap)             state_d = ST_HANDLER;
      else if (bus.eret_m)  state_d = ST_NORMAL;
      else if (sr_wr)       state_d = exl_state_e'(bus.cp0_wdata[SR_EXL_BIT]);
   end

   // Next values of the data-path CP0 fields
   always_comb begin
      im_d      = im_q;
      ie_d      = ie_q;
      bd_d      = bd_q;
      exccode_d = exccode_q;
      epc_d     = epc_q;
      if (trap) begin
         bd_d      = bus.bd_m;
         exccode_d = int_pend ? EXC_INT : bus.exc_code_m;
         // Delay-slot victims restart at the branch; wraps modulo 2^32
         epc_d     = bus.bd_m ? (bus.pc_m - 32'd4) : bus.pc_m;
      end else begin
         if (sr_wr) begin
            im_d = bus.cp0_wdata[SR_IM_MSB:SR_IM_LSB];
            ie_d = bus.cp0_wdata[SR_IE_BIT];
         end
         if (epc_wr) epc_d = bus.cp0_wdata;
      end
   end

   // Data-path CP0 registers; IP samples the raw lines every cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         im_q      <= '0;
         ie_q      <= 1'b0;
         bd_q      <= 1'b0;
         ip_q      <= '0;
         exccode_q <= EXC_NONE;
         epc_q     <= '0;
      end else begin
         im_q      <= im_d;
         ie_q      <= ie_d;
         bd_q      <= bd_d;
         ip_q      <= bus.hw_int;
         exccode_q <= exccode_d;
         epc_q     <= epc_d;
      end
   end

   // Architectural views and read port (pre-update state, no mtc0 bypass)
   always_comb begin
      sr_word    = {16'h0000, im_q, 8'h00, (state_q == ST_HANDLER), ie_q};
      cause_word = {bd_q, 15'h0000, ip_q, 3'b000, exccode_q, 2'b00};
      case (bus.cp0_addr)
         REG_SR:    bus.cp0_rdata = sr_word;
         REG_CAUSE: bus.cp0_rdata = cause_word;
         REG_EPC:   bus.cp0_rdata = epc_q;
         REG_PRID:  bus.cp0_rdata = PRID_VAL;
         default:   bus.cp0_rdata = 32'h0000_0000;
      endcase
   end

   // Redirect outputs; epc_out forwards a same-cycle mtc0 EPC so eret needs no stall
   always_comb begin
      bus.int_exc_req = trap;
      bus.handler_pc  = HANDLER_PC;
      bus.epc_out     = (bus.cp0_we && (bus.cp0_addr == REG_EPC)) ? bus.cp0_wdata : epc_q;
   end

endmodule : cp0_exc_ctrl
`default_nettype wire

// File: tb/tb_cp0_exc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cp0_exc_ctrl
//  Description : Self-checking bench for cp0_exc_ctrl: directed scenarios
//                followed by randomized traffic against a word-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cp0_exc_ctrl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cp0_exc_ctrl_if bus ();

   cp0_exc_ctrl #(
      .HANDLER_PC (32'h0000_4180),
      .PRID_VAL   (32'h2020_0290)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference state held as whole architectural words
   logic [31:0] m_sr, m_cause, m_epc;
   bit          m_valid = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit m_irq();
      return ((bus.hw_int & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
   endfunction

   function automatic bit m_req();
      return m_irq() || ((bus.exc_code_m != 5'd0) && !m_sr[1]);
   endfunction

   function automatic logic [31:0] m_rdata();
      case (int'(bus.cp0_addr))
         12:      return m_sr;
         13:      return m_cause;
         14:      return m_epc;
         15:      return 32'h2020_0290;
         default: return 32'h0;
      endcase
   endfunction

   // Apply inputs on the falling edge, then compare combinational outputs
   task automatic drive(input bit rst, input logic [31:0] pc, input bit bd,
                        input logic [4:0] exc, input logic [5:0] hw, input bit we,
                        input logic [4:0] addr, input logic [31:0] wd, input bit eret);
      @(negedge clk);
      reset          = rst;
      bus.pc_m       = pc;
      bus.bd_m       = bd;
      bus.exc_code_m = exc;
      bus.hw_int     = hw;
      bus.cp0_we     = we;
      bus.cp0_addr   = addr;
      bus.cp0_wdata  = wd;
      bus.eret_m     = eret;
      #1;
      if (m_valid) begin
         check("req",     {31'b0, bus.int_exc_req}, {31'b0, m_req()});
         check("rdata",   bus.cp0_rdata, m_rdata());
         check("epc_out", bus.epc_out,
               (we && addr == 5'd14) ? wd : m_epc);
         check("handler", bus.handler_pc, 32'h0000_4180);
      end
   endtask

   // Advance the model across the rising edge using the held inputs
   task automatic tick();
      bit          take, irq;
      logic [31:0] code;
      @(posedge clk);
      if (reset) begin
         m_sr = 0; m_cause = 0; m_epc = 0;
         m_valid = 1'b1;
      end else begin
         take = m_req();
         irq  = m_irq();
         m_cause = (m_cause & ~32'h0000_FC00) | (32'(bus.hw_int) << 10);
         if (take) begin
            code    = irq ? 32'd0 : 32'(bus.exc_code_m);
            m_cause = (m_cause & 32'h0000_FC00) | (32'(bus.bd_m) << 31) | (code << 2);
            m_epc   = bus.bd_m ? bus.pc_m - 32'd4 : bus.pc_m;
            m_sr    = m_sr | 32'h2;
         end else begin
            if (bus.cp0_we && bus.cp0_addr == 5'd12) m_sr  = bus.cp0_wdata & 32'h0000_FC03;
            if (bus.cp0_we && bus.cp0_addr == 5'd14) m_epc = bus.cp0_wdata;
            if (bus.eret_m) m_sr = m_sr & ~32'h2;
         end
      end
   endtask

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();

      // Reset state
      drive(0, 32'h3000, 0, 0, 6'b000000, 0, 12, 0, 0);
      check("rst_sr", bus.cp0_rdata, 32'h0);
      check("rst_req", {31'b0, bus.int_exc_req}, 32'h0);
      check("rst_epc", bus.epc_out, 32'h0);
      tick();

      // Interrupt trap
      drive(0, 32'h3004, 0, 0, 6'b000000, 1, 12, 32'h0000_FC01, 0); tick();
      drive(0, 32'h3010, 0, 0, 6'b000100, 0, 12, 0, 0);
      check("sr_write", bus.cp0_rdata, 32'h0000_FC01);
      check("irq_req", {31'b0, bus.int_exc_req}, 32'h1);
      tick();
      drive(0, 32'h3014, 0, 0, 6'b000100, 0, 13, 0, 0);
      check("irq_cause", bus.cp0_rdata, 32'h0000_1000); tick();
      drive(0, 32'h3014, 0, 0, 6'b000100, 0, 14, 0, 0);
      check("irq_epc", bus.cp0_rdata, 32'h0000_3010); tick();
      drive(0, 32'h3014, 0, 0, 6'b000100, 0, 12, 0, 0);
      check("irq_sr", bus.cp0_rdata, 32'h0000_FC03); tick();

      // Synchronous exception in a delay slot with interrupts disabled
      drive(0, 32'h3018, 0, 0, 6'b000100, 1, 12, 32'h0, 0); tick();
      drive(0, 32'h3020, 1, 5'd12, 6'b000000, 0, 12, 0, 0);
      check("exc_req", {31'b0, bus.int_exc_req}, 32'h1); tick();
      drive(0, 32'h3024, 0, 0, 6'b000000, 0, 14, 0, 0);
      check("bd_epc", bus.cp0_rdata, 32'h0000_301C); tick();
      drive(0, 32'h3024, 0, 0, 6'b000000, 0, 13, 0, 0);
      check("bd_cause", bus.cp0_rdata, 32'h8000_0030); tick();

      // Interrupt beats exception
      drive(0, 32'h3028, 0, 0, 6'b000000, 1, 12, 32'h0000_FC01, 0); tick();
      drive(0, 32'h3030, 0, 5'd4, 6'b100000, 0, 13, 0, 0);
      check("prio_req", {31'b0, bus.int_exc_req}, 32'h1); tick();
      drive(0, 32'h3034, 0, 0, 6'b100000, 0, 13, 0, 0);
      check("prio_cause", bus.cp0_rdata, 32'h0000_8000); tick();
      drive(0, 32'h3034, 0, 0, 6'b100000, 0, 14, 0, 0);
      check("prio_epc", bus.cp0_rdata, 32'h0000_3030); tick();

      // Masked in handler, eret reopens
      drive(0, 32'h3038, 0, 5'd10, 6'b100000, 0, 14, 0, 0);
      check("exl_mask", {31'b0, bus.int_exc_req}, 32'h0);
      check("exl_epc", bus.cp0_rdata, 32'h0000_3030); tick();
      drive(0, 32'h303C, 0, 0, 6'b100000, 0, 14, 0, 1); tick();
      drive(0, 32'h3100, 0, 0, 6'b100000, 0, 12, 0, 0);
      check("eret_sr", bus.cp0_rdata, 32'h0000_FC01);
      check("eret_req", {31'b0, bus.int_exc_req}, 32'h1); tick();

      // mtc0 discarded by its own trap; bypass on a later write
      drive(0, 32'h3104, 0, 0, 6'b000000, 1, 12, 32'h0, 0); tick();
      drive(0, 32'h3040, 0, 5'd5, 6'b000000, 1, 14, 32'h0000_4000, 0);
      check("discard_req", {31'b0, bus.int_exc_req}, 32'h1); tick();
      drive(0, 32'h3044, 0, 0, 6'b000000, 0, 14, 0, 0);
      check("discard_epc", bus.cp0_rdata, 32'h0000_3040); tick();
      drive(0, 32'h3048, 0, 0, 6'b000000, 1, 14, 32'h0000_5000, 0);
      check("bypass_out", bus.epc_out, 32'h0000_5000);
      check("no_rd_bypass", bus.cp0_rdata, 32'h0000_3040); tick();

      // Reset mid-handler
      drive(0, 32'h304C, 0, 0, 6'b000000, 1, 14, 32'h0000_3010, 0); tick();
      drive(0, 32'h3050, 0, 0, 6'b000100, 0, 14, 0, 0);
      check("pre_rst_epc", bus.cp0_rdata, 32'h0000_3010); tick();
      drive(1, 32'h3054, 0, 5'd5, 6'b000100, 1, 14, 32'h0000_7777, 1); tick();
      drive(0, 32'h3058, 0, 0, 6'b000100, 0, 13, 0, 0);
      check("mid_rst_cause", bus.cp0_rdata, 32'h0);
      check("mid_rst_req", {31'b0, bus.int_exc_req}, 32'h0);
      check("mid_rst_epc", bus.epc_out, 32'h0); tick();
      drive(0, 32'h305C, 0, 0, 6'b000100, 0, 13, 0, 0);
      check("ip_track", bus.cp0_rdata, 32'h0000_1000); tick();

      // EPC wrap for a delay-slot trap at address 0
      drive(0, 32'h0, 1, 5'd12, 6'b000000, 0, 12, 0, 0);
      check("wrap_req", {31'b0, bus.int_exc_req}, 32'h1); tick();
      drive(0, 32'h4, 0, 0, 6'b000000, 0, 14, 0, 0);
      check("wrap_epc", bus.cp0_rdata, 32'hFFFF_FFFC); tick();

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         bit          r_rst, r_bd, r_we, r_eret;
         logic [4:0]  r_exc, r_addr;
         logic [5:0]  r_hw;
         logic [31:0] r_pc, r_wd;
         r_rst = ($urandom_range(0, 63) == 0);
         r_pc  = $urandom;
         r_bd  = $urandom_range(0, 1) == 1;
         case ($urandom_range(0, 11))
            0:       r_exc = 5'd4;
            1:       r_exc = 5'd5;
            2:       r_exc = 5'd10;
            3:       r_exc = 5'd12;
            4:       r_exc = 5'($urandom_range(1, 31));
            default: r_exc = 5'd0;
         endcase
         r_hw   = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
         r_we   = ($urandom_range(0, 3) == 0);
         r_addr = 5'($urandom_range(10, 17));
         r_wd   = $urandom;
         r_eret = !r_we && ($urandom_range(0, 7) == 0);
         drive(r_rst, r_pc, r_bd, r_exc, r_hw, r_we, r_addr, r_wd, r_eret);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_cp0_exc_ctrl
`default_nettype wire
